// File: rtl/pislip_pkg.sv
// Shared p-iSLIP types and helpers: size defaults,
// one-hot checks, index/priority encoders, VOQ state.
package pislip_pkg;

    localparam int PORT_DEF     = 8;
    localparam int PRIORITY_DEF = 4;
    localparam int DEPTH_DEF    = 16;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } voq_state_e;

    function automatic logic onehot_valid(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) n += 32'(v[i]);
        return n == 1;
    endfunction

    function automatic logic [5:0] onehot_to_index(input logic [63:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < 64; i++) if (v[i]) idx = 6'(i);
        return idx;
    endfunction

    // Lowest set bit wins; result is one-hot or zero.
    function automatic logic [63:0] fixed_prio_enc(input logic [63:0] v);
        return v & (~v + 64'd1);
    endfunction

endpackage

// File: rtl/voq_counter.sv
// Saturating occupancy counter for one VOQ with
// EMPTY/ACTIVE/FULL tracking; inc+dec together is a no-op.
module voq_counter
    import pislip_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output voq_state_e    state_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [CW-1:0] count_q, count_d;
    voq_state_e    state_q, state_d;
    logic          up, dn;

    assign full_o  = (state_q == FULL);
    assign empty_o = (state_q == EMPTY);
    assign up      = inc_i & ~dec_i & ~full_o;
    assign dn      = dec_i & ~inc_i & ~empty_o;

    // Next count and state from the net movement this cycle.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (up) count_d = count_q + CW'(1);
        if (dn) count_d = count_q - CW'(1);
        unique case (state_q)
            EMPTY: begin
                if (up) state_d = (count_d == CW'(DEPTH)) ? FULL : ACTIVE;
            end
            ACTIVE: begin
                if (up && count_d == CW'(DEPTH)) state_d = FULL;
                if (dn && count_d == '0)          state_d = EMPTY;
            end
            FULL: begin
                if (dn) state_d = (count_d == '0) ? EMPTY : ACTIVE;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Count and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            state_q <= EMPTY;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign count_o = count_q;
    assign state_o = state_q;

endmodule

// File: rtl/voq_arrival_sink.sv
// Per-input VOQ arrival sink feeding p-iSLIP requests.
// Optional ARRIVAL_STATS_EN adds arrival/drop/grant counters.
module voq_arrival_sink
    import pislip_pkg::*;
#(
    parameter int ID       = 0,
    parameter int WIDTH    = 32,
    parameter int PORT     = PORT_DEF,
    parameter int PRIORITY = PRIORITY_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr,
    input  logic [PORT-1:0]          i_wr_port,
    input  logic [PRIORITY-1:0]      i_wr_pri,
    input  logic [WIDTH-1:0]         i_time,
    input  logic                     i_gnt,
    input  logic [PORT-1:0]          i_gnt_port,
    input  logic [PRIORITY-1:0]      i_gnt_pri,
    output logic [PORT*PRIORITY-1:0] o_req,
    output logic [PORT*PRIORITY-1:0] o_req_pri,
    output logic [WIDTH-1:0]         o_last_time,
    output logic                     o_drop,
`ifdef ARRIVAL_STATS_EN
    output logic [31:0]              o_arr_cnt,
    output logic [31:0]              o_drop_cnt,
    output logic [31:0]              o_gnt_cnt,
`endif
    output logic                     o_err
);

    localparam int N  = PORT * PRIORITY;
    localparam int CW = $clog2(DEPTH + 1);

    if (ID < 0) begin : g_id_chk
        $error("voq_arrival_sink: negative ID");
    end

    logic                wr_q, gnt_q;
    logic [PORT-1:0]     wr_port_q, gnt_port_q;
    logic [PRIORITY-1:0] wr_pri_q, gnt_pri_q;
    logic [WIDTH-1:0]    time_q;
    logic                wr_ok, gnt_ok, mal;

    logic [N-1:0]  inc, dec, full, empty, nonempty;
    logic [CW-1:0] cnt [N];
    voq_state_e    st [N];

    logic hit_full, hit_empty, arr_acc;
    logic [N-1:0] req_d, req_pri_d;
    logic [N-1:0] req_q, req_pri_q;
    logic [WIDTH-1:0] last_time_q;
    logic drop_q, err_q;

    assign wr_ok  = i_wr
                  & onehot_valid(64'(i_wr_port))
                  & onehot_valid(64'(i_wr_pri));
    assign gnt_ok = i_gnt
                  & onehot_valid(64'(i_gnt_port))
                  & onehot_valid(64'(i_gnt_pri));
    assign mal    = (i_wr & ~wr_ok) | (i_gnt & ~gnt_ok);

    // Stage 1: capture well-formed strobes; malformed ones are squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= 1'b0;
            gnt_q      <= 1'b0;
            wr_port_q  <= '0;
            wr_pri_q   <= '0;
            gnt_port_q <= '0;
            gnt_pri_q  <= '0;
            time_q     <= '0;
        end else begin
            wr_q       <= wr_ok;
            gnt_q      <= gnt_ok;
            wr_port_q  <= i_wr_port;
            wr_pri_q   <= i_wr_pri;
            gnt_port_q <= i_gnt_port;
            gnt_pri_q  <= i_gnt_pri;
            time_q     <= i_time;
        end
    end

    for (genvar p = 0; p < PORT; p++) begin : g_port
        for (genvar q = 0; q < PRIORITY; q++) begin : g_pri
            localparam int I = p * PRIORITY + q;
            assign inc[I] = wr_q & wr_port_q[p] & wr_pri_q[q];
            assign dec[I] = gnt_q & gnt_port_q[p] & gnt_pri_q[q];
            voq_counter #(.DEPTH(DEPTH), .CW(CW)) u_cnt (
                .clk    (clk),
                .rst_n  (rst_n),
                .inc_i  (inc[I]),
                .dec_i  (dec[I]),
                .count_o(cnt[I]),
                .state_o(st[I]),
                .full_o (full[I]),
                .empty_o(empty[I])
            );
            assign req_d[I]    = (cnt[I] != '0);
            assign nonempty[I] = (st[I] != EMPTY);
        end
        assign req_pri_d[p*PRIORITY +: PRIORITY] =
            PRIORITY'(fixed_prio_enc(64'(nonempty[p*PRIORITY +: PRIORITY])));
    end

    assign hit_full  = |(inc & ~dec & full);
    assign hit_empty = |(dec & ~inc & empty);
    assign arr_acc   = wr_q & ~hit_full;

    // Stage 2 side effects and registered request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            req_pri_q   <= '0;
            last_time_q <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            req_q     <= req_d;
            req_pri_q <= req_pri_d;
            drop_q    <= hit_full;
            err_q     <= err_q | mal | hit_empty;
            if (arr_acc) last_time_q <= time_q;
        end
    end

`ifdef ARRIVAL_STATS_EN
    logic [31:0] arr_cnt_q, drop_cnt_q, gnt_cnt_q;

    // Free-running event statistics, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_cnt_q  <= '0;
            drop_cnt_q <= '0;
            gnt_cnt_q  <= '0;
        end else begin
            if (arr_acc)            arr_cnt_q  <= arr_cnt_q + 32'd1;
            if (hit_full)           drop_cnt_q <= drop_cnt_q + 32'd1;
            if (gnt_q & ~hit_empty) gnt_cnt_q  <= gnt_cnt_q + 32'd1;
        end
    end

    assign o_arr_cnt  = arr_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_gnt_cnt  = gnt_cnt_q;
`endif

    assign o_req       = req_q;
    assign o_req_pri   = req_pri_q;
    assign o_last_time = last_time_q;
    assign o_drop      = drop_q;
    assign o_err       = err_q;

endmodule

// File: doc/voq_arrival_sink.md
Name: voq_arrival_sink

Overview:
- Input-port receiver for the frame/priority arrival stream (wr pulse, one-hot port, one-hot priority, timestamp) produced by the per-input traffic generators.
- Keeps virtual-output-queue occupancy counters per (output port, priority) and presents request vectors to the p-iSLIP scheduler.
- Consumes scheduler grants as dequeues and flags protocol violations.
- One instance per switch input, between the generator and the scheduler request stage.

Parameters:
- ID, 0, input index, used only in error reporting
- WIDTH, 32, timestamp width
- PORT, 8, number of output ports (one-hot width)
- PRIORITY, 4, number of priority classes (one-hot width; bit 0 = highest)
- DEPTH, 16, max frames per VOQ; counter width CW = $clog2(DEPTH+1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_wr  in  1  arrival strobe, one cycle per frame
- i_wr_port  in  PORT  one-hot destination port
- i_wr_pri  in  PRIORITY  one-hot priority
- i_time  in  WIDTH  arrival timestamp
- i_gnt  in  1  scheduler grant/dequeue strobe
- i_gnt_port  in  PORT  one-hot granted port
- i_gnt_pri  in  PRIORITY  one-hot granted priority
- o_req  out  PORT*PRIORITY  bit p*PRIORITY+q set when VOQ(p,q) is non-empty
- o_req_pri  out  PORT*PRIORITY  per port, one-hot highest non-empty priority (0 if none)
- o_last_time  out  WIDTH  timestamp of last accepted arrival
- o_drop  out  1  one-cycle pulse: arrival rejected (VOQ full)
- o_err  out  1  sticky: malformed one-hot or dequeue of empty VOQ

Behaviour:
- Reset (async, rst_n=0): all counters 0; o_req, o_req_pri, o_last_time 0; o_drop 0; o_err 0.
- Stage 1 (capture): register i_wr/i_gnt with their port, pri and time. Malformed strobe (not exactly one bit set in port or pri): squash the event, set o_err.
- Stage 2 (update), acting on registered events:
  - Arrival to VOQ(p,q) with count < DEPTH: count+1; o_last_time <= captured time.
  - Arrival with count == DEPTH: count unchanged; o_drop=1 for one cycle; o_last_time unchanged.
  - Grant to VOQ(p,q) with count > 0: count-1. With count == 0: ignored; o_err set.
  - Arrival and grant to the same VOQ in the same cycle: count unchanged, no drop even when full; o_last_time updated.
  - Arrival and grant to different VOQs: both applied independently.
- Outputs registered from counters. Latency: input strobe at cycle N -> counter at N+2 -> o_req/o_req_pri at N+3. o_drop asserts at N+2.
- o_req_pri: fixed-priority encode per port, lowest set index wins.
- Per-VOQ state: EMPTY (count 0), ACTIVE (1..DEPTH-1), FULL (DEPTH).
  - EMPTY->ACTIVE on net +1.
  - ACTIVE->FULL when count reaches DEPTH.
  - FULL->ACTIVE on net -1.
  - ACTIVE->EMPTY when count reaches 0.
- No arithmetic wrap: counters saturate at both ends per the rules above.
- o_err clears only on reset.
- Reset mid-operation discards pipeline contents immediately.

Optional Feature:
- ARRIVAL_STATS_EN defined: adds outputs o_arr_cnt [31:0], o_drop_cnt [31:0], o_gnt_cnt [31:0].
  - Free-running, wrap at 2^32, reset to 0.
  - Increment on accepted arrival, drop, and accepted grant respectively, in stage 2.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package (pislip_pkg):
  - PORT, PRIORITY, DEPTH defaults
  - onehot-valid function
  - onehot-to-index function
  - fixed-priority-encode function
  - VOQ state enum {EMPTY, ACTIVE, FULL}
- Sub-module voq_counter: one per (port, priority) via generate.
  - Inputs: inc, dec.
  - Outputs: count, state, full, empty.
  - Implements saturation and the simultaneous inc/dec rule.

Test Plan:
- Reset, then three arrivals port=8'b0000_0100, pri=4'b0010, times 100/200/300 -> o_req bit 9 set at strobe+3, count 3, o_last_time=300, o_req_pri port2 = 4'b0010.
- 17 arrivals to VOQ(0,0) with DEPTH=16 -> 17th produces single o_drop pulse, count stays 16; with ARRIVAL_STATS_EN, o_arr_cnt=16, o_drop_cnt=1.
- VOQ(3,3) at count 1 plus arrival to VOQ(3,1) -> o_req_pri port3 = 4'b0010; grant (3,1) -> o_req_pri port3 = 4'b1000.
- VOQ(5,0) full (16), simultaneous arrival and grant to (5,0) -> count 16, no o_drop; next grant alone -> 15.
- Grant to empty VOQ(1,2), and separately i_wr with i_wr_port=8'b0000_0011 -> no counter change, o_err=1 and stays high until rst_n.
- Assert rst_n=0 asynchronously mid-burst, with events in the pipeline -> all outputs 0 immediately; after release, no stale event applied.
